// File: rtl/key_reg_bank_if.sv
// key_reg_bank_if
//   Bundles the key-delivery controls and key outputs of key_reg_bank.
//   master : key-delivery side (drives CLEAR/PRESET/EN/MODE/D/SI/LOCK,
//            observes Q/SO/LOADED/LOCKED)
//   slave  : the key register itself
//   Signals:
//     CLEAR  sync clear          PRESET sync preset       EN   load enable
//     MODE   0=parallel,1=serial D      parallel key data SI   serial key in
//     LOCK   freeze request      Q      key value         SO   serial out
//     LOADED full key present    LOCKED key frozen
interface key_reg_bank_if #(
   parameter int WIDTH = 8
);
   logic             CLEAR;
   logic             PRESET;
   logic             EN;
   logic             MODE;
   logic [WIDTH-1:0] D;
   logic             SI;
   logic             LOCK;
   logic [WIDTH-1:0] Q;
   logic             SO;
   logic             LOADED;
   logic             LOCKED;

   modport master (
      output CLEAR, PRESET, EN, MODE, D, SI, LOCK,
      input  Q, SO, LOADED, LOCKED
   );

   modport slave (
      input  CLEAR, PRESET, EN, MODE, D, SI, LOCK,
      output Q, SO, LOADED, LOCKED
   );
endinterface

// File: rtl/key_reg_bank.sv
// key_reg_bank
//   WIDTH-bit locking-key register placed between the key-delivery interface
//   and the key inputs of a locked netlist. The key is loaded either in one
//   cycle from D or shifted in bit by bit from SI. Once a full key is present
//   a LOCK request freezes it; only the asynchronous reset releases it.
//   Ports:
//     CLK  clock, rising edge
//     RST  asynchronous reset, active-low
//     bus  key_reg_bank_if.slave (controls in, Q/SO/LOADED/LOCKED out)
module key_reg_bank #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
   input  logic          CLK,
   input  logic          RST,
   key_reg_bank_if.slave bus
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILLING,
      ST_FULL,
      ST_LOCKED
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] shift_val;
   logic [CW-1:0]    cnt_inc;
   logic             loaded;

   // Serial path: new bit enters at the LSB, the MSB falls out on SO.
   generate
      if (WIDTH == 1) begin : g_shift_w1
         assign shift_val = bus.SI;
      end else begin : g_shift_wn
         assign shift_val = {q_reg[WIDTH-2:0], bus.SI};
      end
   endgenerate

   // Bit count saturates at WIDTH so shifting a full key keeps it full.
   assign cnt_inc = (cnt_reg == CNT_FULL) ? CNT_FULL : cnt_reg + CW'(1);

   assign loaded = (state_reg == ST_FULL) || (state_reg == ST_LOCKED);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg <= ST_EMPTY;
         q_reg     <= RESET_VAL;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      cnt_next   = cnt_reg;
      // A locked key is frozen: every control is ignored until reset.
      if (state_reg != ST_LOCKED) begin
         if (bus.CLEAR) begin
            q_next     = '0;
            cnt_next   = '0;
            state_next = ST_EMPTY;
         end else if (bus.PRESET) begin
            q_next     = PRESET_VAL;
            cnt_next   = CNT_FULL;
            state_next = ST_FULL;
         end else if (bus.LOCK && loaded) begin
            // Honoured lock swallows any load on the same edge.
            state_next = ST_LOCKED;
         end else if (bus.EN) begin
            if (!bus.MODE) begin
               q_next     = bus.D;
               cnt_next   = CNT_FULL;
               state_next = ST_FULL;
            end else begin
               q_next     = shift_val;
               cnt_next   = cnt_inc;
               state_next = (cnt_inc == CNT_FULL) ? ST_FULL : ST_FILLING;
            end
         end
      end
   end

   assign bus.Q      = q_reg;
   assign bus.SO     = q_reg[WIDTH-1];
   assign bus.LOADED = loaded;
   assign bus.LOCKED = (state_reg == ST_LOCKED);

   // An unknown MODE during a load would make the load path ambiguous.
   mode_known_a : assert property (@(posedge CLK) disable iff (!RST)
                                   bus.EN |-> !$isunknown(bus.MODE));

endmodule

// File: tb/tb_key_reg_bank.sv
module tb_key_reg_bank;

   typedef struct {
      string      name;
      bit         w1;
      logic [7:0] q;
      logic       so;
      logic       ld;
      logic       lk;
   } exp_t;

   logic CLK;
   logic RST;
   int   total = 0;
   int   bad   = 0;

   exp_t sb[$];
   exp_t rq[$];
   event rst_evt;

   key_reg_bank_if #(.WIDTH(8)) bus8 ();
   key_reg_bank_if #(.WIDTH(1)) bus1 ();

   key_reg_bank #(.WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8.slave));
   key_reg_bank #(.WIDTH(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic compare(input exp_t e);
      logic [10:0] act, req;
      if (e.w1)
         act = {7'b0, bus1.Q, bus1.SO, bus1.LOADED, bus1.LOCKED};
      else
         act = {bus8.Q, bus8.SO, bus8.LOADED, bus8.LOCKED};
      req = {e.q, e.so, e.ld, e.lk};
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got q=%h so=%b loaded=%b locked=%b, want q=%h so=%b loaded=%b locked=%b",
                  e.name, act[10:3], act[2], act[1], act[0], e.q, e.so, e.ld, e.lk);
      end else begin
         $display("ok   %s: q=%h so=%b loaded=%b locked=%b", e.name, e.q, e.so, e.ld, e.lk);
      end
   endtask

   // Monitor: outputs are presented one step after each rising edge.
   always @(posedge CLK) begin
      #1;
      while (sb.size() > 0) compare(sb.pop_front());
   end

   // Monitor for the asynchronous reset, which presents outputs with no edge.
   always @(rst_evt) begin
      #1;
      while (rq.size() > 0) compare(rq.pop_front());
   end

   function automatic exp_t mk(input string n, input bit w1, input logic [7:0] q,
                               input logic so, input logic ld, input logic lk);
      exp_t e;
      e.name = n; e.w1 = w1; e.q = q; e.so = so; e.ld = ld; e.lk = lk;
      return e;
   endfunction

   task automatic drv8(input logic clr, input logic pre, input logic lck, input logic en,
                       input logic mode, input logic [7:0] d, input logic si);
      bus8.CLEAR = clr; bus8.PRESET = pre; bus8.LOCK = lck; bus8.EN = en;
      bus8.MODE = mode; bus8.D = d; bus8.SI = si;
   endtask

   task automatic drv1(input logic clr, input logic pre, input logic lck, input logic en,
                       input logic mode, input logic si);
      bus1.CLEAR = clr; bus1.PRESET = pre; bus1.LOCK = lck; bus1.EN = en;
      bus1.MODE = mode; bus1.D = 1'b0; bus1.SI = si;
   endtask

   task automatic cycle_end();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic async_reset_check(input string n);
      #1;
      RST = 1'b0;
      rq.push_back(mk({n, "_w8"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      rq.push_back(mk({n, "_w1"}, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
      -> rst_evt;
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   logic [7:0] ser_q [8];
   logic       ser_si[8];
   logic [7:0] ev;

   initial begin
      ser_q  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
      ser_si = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      RST = 1'b0;
      drv8(0, 0, 0, 0, 0, 8'h00, 0);
      drv1(0, 0, 0, 0, 0, 0);
      async_reset_check("reset_init");
      @(negedge CLK);
      RST = 1'b1;

      // WIDTH=1: one shift fills the key, lock freezes it.
      drv1(0, 0, 0, 1, 1, 1);
      sb.push_back(mk("w1_shift", 1'b1, 8'h01, 1'b1, 1'b1, 1'b0));
      cycle_end();
      drv1(0, 0, 1, 0, 0, 0);
      sb.push_back(mk("w1_lock", 1'b1, 8'h01, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv1(1, 1, 0, 1, 1, 0);
      sb.push_back(mk("w1_frozen", 1'b1, 8'h01, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv1(0, 0, 0, 0, 0, 0);

      // Parallel load, lock, then everything ignored.
      drv8(0, 0, 0, 1, 0, 8'hA5, 0);
      sb.push_back(mk("par_load", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0));
      cycle_end();
      drv8(0, 0, 1, 0, 0, 8'h00, 0);
      sb.push_back(mk("par_lock", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv8(1, 0, 0, 1, 0, 8'h3C, 0);
      sb.push_back(mk("locked_clr_en", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv8(0, 1, 0, 0, 0, 8'h00, 0);
      sb.push_back(mk("locked_preset", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv8(0, 0, 0, 0, 0, 8'h00, 0);

      // Mid-run async reset releases both locked registers without a clock edge.
      async_reset_check("reset_mid");
      RST = 1'b1;

      // Serial load of 8'hB2; LOADED only on the 8th edge.
      for (int i = 0; i < 8; i++) begin
         drv8(0, 0, 0, 1, 1, 8'h00, ser_si[i]);
         ev = ser_q[i];
         sb.push_back(mk($sformatf("ser_%0d", i), 1'b0, ev, ev[7], (i == 7), 1'b0));
         cycle_end();
      end
      drv8(0, 0, 0, 1, 1, 8'h00, 1);
      sb.push_back(mk("ser_full_shift", 1'b0, 8'h65, 1'b0, 1'b1, 1'b0));
      cycle_end();

      // CLEAR beats PRESET and EN; then PRESET alone.
      drv8(1, 1, 0, 1, 0, 8'h77, 0);
      sb.push_back(mk("clr_pre_en", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      cycle_end();
      drv8(0, 1, 0, 0, 0, 8'h00, 0);
      sb.push_back(mk("preset", 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0));
      cycle_end();
      drv8(1, 0, 0, 0, 0, 8'h00, 0);
      sb.push_back(mk("clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      cycle_end();

      // Three shifts, ignored LOCK, five more shifts.
      for (int i = 0; i < 3; i++) begin
         drv8(0, 0, 0, 1, 1, 8'h00, 1);
         ev = 8'((1 << (i + 1)) - 1);
         sb.push_back(mk($sformatf("part_%0d", i), 1'b0, ev, 1'b0, 1'b0, 1'b0));
         cycle_end();
      end
      drv8(0, 0, 1, 0, 0, 8'h00, 0);
      sb.push_back(mk("lock_ignored", 1'b0, 8'h07, 1'b0, 1'b0, 1'b0));
      cycle_end();
      for (int i = 0; i < 5; i++) begin
         drv8(0, 0, 0, 1, 1, 8'h00, 1);
         ev = 8'((1 << (i + 4)) - 1);
         sb.push_back(mk($sformatf("rest_%0d", i), 1'b0, ev, ev[7], (i == 4), 1'b0));
         cycle_end();
      end

      // Lock with a simultaneous parallel load: the load is dropped.
      drv8(0, 0, 1, 1, 0, 8'h00, 0);
      sb.push_back(mk("lock_over_en", 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv8(1, 0, 0, 1, 1, 8'h00, 0);
      sb.push_back(mk("locked_clr_shift", 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1));
      cycle_end();
      drv8(0, 0, 0, 0, 0, 8'h00, 0);

      cycle_end();
      total++;
      if (sb.size() != 0 || rq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size() + rq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
